// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its tick generator.
package seg_pkg;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } scan_state_t;

    localparam int DEFAULT_REFRESH_DIV = 125000;

    localparam logic DIG_LO = 1'b0;
    localparam logic DIG_HI = 1'b1;

    // Picks the nibble shown for a given digit select.
    function automatic logic [3:0] digit_nibble(input logic [7:0] value, input logic sel);
        return sel ? value[7:4] : value[3:0];
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running refresh counter; tick marks the terminal count of each digit slot.
module seg_tick_gen
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Gating with en lets a frozen terminal cycle hold its transition until release.
    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit scan controller with frame-aligned double buffering for the hex decoder stage.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       freeze,
    output logic [3:0] din,
    output logic       sel_in,
    output logic       pending,
    output logic       frame_done
);

    scan_state_t state;
    logic [7:0]  disp;
    logic [7:0]  pend;
    logic        tick;
    logic        boundary;

    seg_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (!freeze),
        .tick(tick)
    );

    assign boundary = tick && (state == DIG1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DIG0;
            disp       <= '0;
            pend       <= '0;
            pending    <= 1'b0;
            din        <= '0;
            sel_in     <= DIG_LO;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;

            // A write coinciding with the boundary lands after the old value is transferred.
            if (wr_en) begin
                pend    <= wr_data;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end

            if (tick) begin
                if (state == DIG0) begin
                    state  <= DIG1;
                    sel_in <= DIG_HI;
                    din    <= digit_nibble(disp, DIG_HI);
                end else begin
                    state  <= DIG0;
                    sel_in <= DIG_LO;
                    if (pending) begin
                        disp <= pend;
                        din  <= digit_nibble(pend, DIG_LO);
                    end else begin
                        din  <= digit_nibble(disp, DIG_LO);
                    end
                end
            end
        end
    end

endmodule
